// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the 5-stage pipeline interlock controller:
//   - default parameter values (register address width, HALT drain length,
//     performance counter width)
//   - interlock FSM state encodings
//   - NOP instruction word loaded by the bubble and flush paths
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_e;

    // addi x0, x0, 0 -- written into IF_ID / ID_EXE when a bubble or flush
    // replaces the real instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per architectural register. A bit is set when an instruction
// that writes that register issues, and cleared when WB writes it back.
// Register 0 is hard-wired to never be busy.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   set_en, set_addr    mark set_addr busy at the next edge
//   clr_en, clr_addr    mark clr_addr free at the next edge
//   chk_valid           the checked instruction is real
//   rs1/rs1_en, rs2/rs2_en, rd/rd_en   registers of the checked instruction
//   haz                 checked instruction touches a busy register
//   all_clear           no register is busy
// ---------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              chk_valid,
    input  logic [ADDR_W-1:0] rs1,
    input  logic              rs1_en,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              rs2_en,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_en,
    output logic              haz,
    output logic              all_clear
);
    import pipe_hazard_ctrl_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    assign busy_d[0] = 1'b0;

    // Set takes precedence over clear: if a register that was never marked
    // busy is written back while a new writer issues, the new write is the
    // one still outstanding. A busy target can never be set in the same
    // cycle because the WAW term of haz blocks the issue.
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
            assign busy_d[gi] = (set_en && set_addr == ADDR_W'(gi)) ||
                                (busy_q[gi] && !(clr_en && clr_addr == ADDR_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // No bypass: a register cleared at edge N only unblocks ID in cycle N+1.
    assign haz = chk_valid && ((rs1_en && busy_q[rs1]) ||
                               (rs2_en && busy_q[rs2]) ||
                               (rd_en  && busy_q[rd]));

    assign all_clear = ~|busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central interlock controller for the IF/ID/EXE/MEM/WB pipeline. Detects
// RAW/WAW hazards at ID through a register scoreboard, squashes on taken
// branches, and sequences HALT: drain the pipeline, then assert sticky halt.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_*                       decoded fields of the instruction in IF_ID
//   exe_br_taken               branch/jump in EXE resolved taken
//   wb_wr_en, wb_rd            register-file write-back
//   stall_if                   hold PC and IF_ID
//   bubble_ex                  load a NOP into ID_EXE
//   flush_if_id                replace IF_ID with a NOP
//   issue                      ID instruction advances into ID_EXE
//   halt                       processor halted (sticky until reset)
//   stall_cnt, flush_cnt       saturating performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_LEN = pipe_hazard_ctrl_pkg::REG_ADDR_LEN,
    parameter int DRAIN_CYCLES = pipe_hazard_ctrl_pkg::DRAIN_CYCLES,
    parameter int CNT_W        = pipe_hazard_ctrl_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_rs1,
    input  logic                    id_rs1_en,
    input  logic [REG_ADDR_LEN-1:0] id_rs2,
    input  logic                    id_rs2_en,
    input  logic [REG_ADDR_LEN-1:0] id_rd,
    input  logic                    id_rd_en,
    input  logic                    id_is_halt,
    input  logic                    exe_br_taken,
    input  logic                    wb_wr_en,
    input  logic [REG_ADDR_LEN-1:0] wb_rd,
    output logic                    stall_if,
    output logic                    bubble_ex,
    output logic                    flush_if_id,
    output logic                    issue,
    output logic                    halt,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);
    import pipe_hazard_ctrl_pkg::*;

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    hz_state_e          state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic haz;
    logic all_clear;
    logic sb_set_en;
    logic sb_clr_en;

    assign sb_set_en = issue && id_rd_en && (id_rd != '0);
    // Once halted every input is ignored, including write-backs.
    assign sb_clr_en = wb_wr_en && (state_q != ST_HALTED);

    reg_scoreboard #(
        .ADDR_W (REG_ADDR_LEN)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (sb_set_en),
        .set_addr  (id_rd),
        .clr_en    (sb_clr_en),
        .clr_addr  (wb_rd),
        .chk_valid (id_valid),
        .rs1       (id_rs1),
        .rs1_en    (id_rs1_en),
        .rs2       (id_rs2),
        .rs2_en    (id_rs2_en),
        .rd        (id_rd),
        .rd_en     (id_rd_en),
        .haz       (haz),
        .all_clear (all_clear)
    );

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (exe_br_taken) begin
                    if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end else if (haz) begin
                    if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end else if (id_valid && id_is_halt) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                // exe_br_taken cannot legitimately occur here; it is ignored.
                if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                if (drain_cnt_q == '0 && all_clear) state_d = ST_HALTED;
            end
            ST_HALTED: begin
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Pipeline control outputs
    always_comb begin
        stall_if    = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        issue       = 1'b0;
        halt        = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (exe_br_taken) begin
                    // Squashes whatever sits in ID, HALT or hazarded included.
                    flush_if_id = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (haz) begin
                    stall_if  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (id_valid) begin
                    issue    = 1'b1;
                    // HALT issues but freezes fetch behind it.
                    stall_if = id_is_halt;
                end
            end
            ST_DRAIN: begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
            ST_HALTED: begin
                halt      = 1'b1;
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: begin
            end
        endcase
        // Outputs are combinational from live inputs, so hold them low while
        // reset is asserted rather than waiting for the state to settle.
        if (!rst_n) begin
            stall_if    = 1'b0;
            bubble_ex   = 1'b0;
            flush_if_id = 1'b0;
            issue       = 1'b0;
            halt        = 1'b0;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic        id_rs1_en;
    logic [4:0]  id_rs2;
    logic        id_rs2_en;
    logic [4:0]  id_rd;
    logic        id_rd_en;
    logic        id_is_halt;
    logic        exe_br_taken;
    logic        wb_wr_en;
    logic [4:0]  wb_rd;
    logic        stall_if;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        issue;
    logic        halt;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs1_en    (id_rs1_en),
        .id_rs2       (id_rs2),
        .id_rs2_en    (id_rs2_en),
        .id_rd        (id_rd),
        .id_rd_en     (id_rd_en),
        .id_is_halt   (id_is_halt),
        .exe_br_taken (exe_br_taken),
        .wb_wr_en     (wb_wr_en),
        .wb_rd        (wb_rd),
        .stall_if     (stall_if),
        .bubble_ex    (bubble_ex),
        .flush_if_id  (flush_if_id),
        .issue        (issue),
        .halt         (halt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_rs1       = 5'd0;
        id_rs1_en    = 1'b0;
        id_rs2       = 5'd0;
        id_rs2_en    = 1'b0;
        id_rd        = 5'd0;
        id_rd_en     = 1'b0;
        id_is_halt   = 1'b0;
        exe_br_taken = 1'b0;
        wb_wr_en     = 1'b0;
        wb_rd        = 5'd0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic rs1e,
                          input logic [4:0] rs2, input logic rs2e,
                          input logic [4:0] rd,  input logic rde,
                          input logic hlt);
        id_valid   = 1'b1;
        id_rs1     = rs1;
        id_rs1_en  = rs1e;
        id_rs2     = rs2;
        id_rs2_en  = rs2e;
        id_rd      = rd;
        id_rd_en   = rde;
        id_is_halt = hlt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        id_valid = 1'b1;
        rst_n    = 1'b0;
        #2;
        chk("rst_stall_if",    stall_if,    1'b0);
        chk("rst_bubble_ex",   bubble_ex,   1'b0);
        chk("rst_flush_if_id", flush_if_id, 1'b0);
        chk("rst_issue",       issue,       1'b0);
        chk("rst_halt",        halt,        1'b0);
        chk("rst_stall_cnt",   stall_cnt,   16'h0);
        chk("rst_flush_cnt",   flush_cnt,   16'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            set_id(5'(i + 11), 1'b1, 5'(i + 21), 1'b1, 5'(i + 1), 1'b1, 1'b0);
            #1;
            chk("stream_issue", issue, 1'b1);
            chk("stream_stall", stall_if, 1'b0);
            $display("stream instr %0d issue=%0b stall_if=%0b", i, issue, stall_if);
            tick();
        end
        idle();
        #1;
        chk("stream_stall_cnt", stall_cnt, 16'h0);
        chk("stream_flush_cnt", flush_cnt, 16'h0);
        for (int i = 1; i <= 10; i++) begin
            idle();
            wb_wr_en = 1'b1;
            wb_rd    = 5'(i);
            tick();
        end
        idle();

        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        #1;
        chk("raw_producer_issue", issue, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            wb_wr_en = (k == 2);
            wb_rd    = 5'd3;
            #1;
            chk("raw_stall_if", stall_if, 1'b1);
            chk("raw_bubble_ex", bubble_ex, 1'b1);
            chk("raw_no_issue", issue, 1'b0);
            $display("raw stall cycle %0d stall_if=%0b bubble_ex=%0b issue=%0b", k, stall_if, bubble_ex, issue);
            tick();
        end
        wb_wr_en = 1'b0;
        #1;
        chk("raw_issue_after_wb", issue, 1'b1);
        chk("raw_stall_released", stall_if, 1'b0);
        chk("raw_bubble_released", bubble_ex, 1'b0);
        tick();
        idle();
        #1;
        chk("raw_stall_cnt", stall_cnt, 16'd3);

        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        exe_br_taken = 1'b1;
        #1;
        chk("br_flush_if_id", flush_if_id, 1'b1);
        chk("br_bubble_ex", bubble_ex, 1'b1);
        chk("br_stall_if", stall_if, 1'b0);
        chk("br_issue", issue, 1'b0);
        $display("branch flush_if_id=%0b bubble_ex=%0b", flush_if_id, bubble_ex);
        tick();
        idle();
        #1;
        chk("br_flush_one_cycle", flush_if_id, 1'b0);
        chk("br_stall_cnt_same", stall_cnt, 16'd3);
        chk("br_flush_cnt", flush_cnt, 16'd1);
        wb_wr_en = 1'b1;
        wb_rd    = 5'd5;
        tick();
        idle();

        for (int k = 0; k < 3; k++) begin
            set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
            #1;
            chk("r0_write_issue", issue, 1'b1);
            tick();
        end
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("r0_read_issue", issue, 1'b1);
        chk("r0_read_stall", stall_if, 1'b0);
        tick();
        idle();
        #1;
        chk("r0_stall_cnt", stall_cnt, 16'd3);

        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (65531) tick();
        chk("sat_below_top", stall_cnt, 16'hFFFE);
        repeat (10) tick();
        chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
        chk("sat_still_stalling", stall_if, 1'b1);
        $display("saturation stall_cnt=%0h", stall_cnt);
        idle();
        wb_wr_en = 1'b1;
        wb_rd    = 5'd9;
        tick();
        idle();

        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        #1;
        chk("halt_issue", issue, 1'b1);
        chk("halt_issue_stall", stall_if, 1'b1);
        chk("halt_issue_bubble", bubble_ex, 1'b0);
        tick();
        idle();
        for (int c = 1; c <= 7; c++) begin
            wb_wr_en = (c == 6);
            wb_rd    = 5'd7;
            #1;
            chk("drain_halt_low", halt, 1'b0);
            chk("drain_stall_if", stall_if, 1'b1);
            chk("drain_bubble_ex", bubble_ex, 1'b1);
            chk("drain_issue", issue, 1'b0);
            $display("drain cycle %0d halt=%0b stall_if=%0b", c, halt, stall_if);
            tick();
        end
        idle();
        #1;
        chk("halt_asserted", halt, 1'b1);
        for (int c = 0; c < 8; c++) begin
            id_valid     = 1'($urandom_range(1));
            id_rs1       = 5'($urandom_range(31));
            id_rs1_en    = 1'($urandom_range(1));
            id_rd        = 5'($urandom_range(31));
            id_rd_en     = 1'($urandom_range(1));
            id_is_halt   = 1'($urandom_range(1));
            exe_br_taken = 1'($urandom_range(1));
            wb_wr_en     = 1'($urandom_range(1));
            wb_rd        = 5'($urandom_range(31));
            #1;
            chk("halted_sticky", halt, 1'b1);
            chk("halted_no_issue", issue, 1'b0);
            chk("halted_no_flush", flush_if_id, 1'b0);
            chk("halted_stall_if", stall_if, 1'b1);
            $display("halted random cycle %0d halt=%0b issue=%0b", c, halt, issue);
            tick();
        end
        idle();
        #1;
        chk("halted_flush_cnt_frozen", flush_cnt, 16'd1);

        rst_n = 1'b0;
        #1;
        chk("unhalt_rst_halt", halt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        chk("mid_drain_stall", stall_if, 1'b1);
        tick();
        id_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall_if",    stall_if,    1'b0);
        chk("arst_bubble_ex",   bubble_ex,   1'b0);
        chk("arst_flush_if_id", flush_if_id, 1'b0);
        chk("arst_issue",       issue,       1'b0);
        chk("arst_halt",        halt,        1'b0);
        chk("arst_stall_cnt",   stall_cnt,   16'h0);
        chk("arst_flush_cnt",   flush_cnt,   16'h0);
        $display("async reset mid-drain stall_if=%0b issue=%0b", stall_if, issue);
        @(negedge clk);
        rst_n = 1'b1;
        set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("post_rst_run_issue", issue, 1'b1);
        chk("post_rst_run_stall", stall_if, 1'b0);
        tick();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
